// File: rtl/ila_readout_ctrl_if.sv
// rtl/ila_readout_ctrl_if.sv - valid/ready word stream from the readout sequencer to the host bridge
interface ila_readout_ctrl_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              ready_i;
    logic              last_o;

    modport master (
        output data_o,
        output valid_o,
        output last_o,
        input  ready_i
    );

    modport slave (
        input  data_o,
        input  valid_o,
        input  last_o,
        output ready_i
    );
endinterface

// File: rtl/ila_readout_ctrl.sv
// rtl/ila_readout_ctrl.sv - drains an ila_core sample buffer word by word onto a valid/ready stream
module ila_readout_ctrl #(
    parameter int DATA_W   = 32,
    parameter int BUFFER_W = 8,
    parameter int SIGNAL_W = 8,
    parameter int SEL_W    = 1,
    parameter int READ_LAT = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [BUFFER_W-1:0] samples_i,
    input  logic [DATA_W-1:0]   value_i,
    output logic [BUFFER_W-1:0] index_o,
    output logic [SEL_W-1:0]    value_select_o,
    output logic                busy_o,
    output logic                done_o,
    ila_readout_ctrl_if.master  stream
);
    localparam int WORDS_RAW = (SIGNAL_W + DATA_W - 1) / DATA_W;
    localparam int WORDS     = (WORDS_RAW < 1) ? 1 : WORDS_RAW;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WORDS - 1);
    localparam logic [1:0]       LAT      = 2'(READ_LAT);

    typedef enum logic [2:0] {IDLE, SETUP, WAIT, OUT, FIN} state_t;

    state_t              state;
    logic [BUFFER_W-1:0] cnt;
    logic [1:0]          lat_cnt;
    logic                last_pos;

    // The word currently addressed is the final one of the whole readout.
    assign last_pos = (index_o == cnt - BUFFER_W'(1)) && (value_select_o == LAST_SEL);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            cnt            <= '0;
            lat_cnt        <= '0;
            index_o        <= '0;
            value_select_o <= '0;
            stream.data_o  <= '0;
            stream.valid_o <= 1'b0;
            stream.last_o  <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (abort_i && state != IDLE && state != FIN) begin
                // Abort wins over a handshake in the same cycle; the pending word is dropped.
                stream.valid_o <= 1'b0;
                stream.last_o  <= 1'b0;
                state          <= FIN;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            cnt            <= samples_i;
                            index_o        <= '0;
                            value_select_o <= '0;
                            busy_o         <= 1'b1;
                            state          <= (samples_i == '0) ? FIN : SETUP;
                        end
                    end
                    SETUP: begin
                        if (READ_LAT == 0) begin
                            stream.data_o  <= value_i;
                            stream.valid_o <= 1'b1;
                            stream.last_o  <= last_pos;
                            state          <= OUT;
                        end else begin
                            lat_cnt <= LAT;
                            state   <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (lat_cnt == 2'd1) begin
                            stream.data_o  <= value_i;
                            stream.valid_o <= 1'b1;
                            stream.last_o  <= last_pos;
                            state          <= OUT;
                        end else begin
                            lat_cnt <= lat_cnt - 2'd1;
                        end
                    end
                    OUT: begin
                        if (stream.valid_o && stream.ready_i) begin
                            stream.valid_o <= 1'b0;
                            stream.last_o  <= 1'b0;
                            if (last_pos) begin
                                state <= FIN;
                            end else begin
                                if (value_select_o != LAST_SEL) begin
                                    value_select_o <= value_select_o + SEL_W'(1);
                                end else begin
                                    value_select_o <= '0;
                                    index_o        <= index_o + BUFFER_W'(1);
                                end
                                state <= SETUP;
                            end
                        end
                    end
                    FIN: begin
                        done_o         <= 1'b1;
                        busy_o         <= 1'b0;
                        index_o        <= '0;
                        value_select_o <= '0;
                        state          <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ila_readout_ctrl.sv
// tb/tb_ila_readout_ctrl.sv - self-checking bench for ila_readout_ctrl with a two-word-per-sample buffer model
module tb_ila_readout_ctrl;
    localparam int DATA_W   = 32;
    localparam int BUFFER_W = 8;
    localparam int SIGNAL_W = 64;
    localparam int SEL_W    = 1;
    localparam int READ_LAT = 1;
    localparam int WORDS    = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                abort;
    logic [BUFFER_W-1:0] samples;
    logic [DATA_W-1:0]   value;
    logic [BUFFER_W-1:0] index;
    logic [SEL_W-1:0]    vsel;
    logic                busy;
    logic                done;

    ila_readout_ctrl_if #(.DATA_W(DATA_W)) st ();

    ila_readout_ctrl #(
        .DATA_W(DATA_W), .BUFFER_W(BUFFER_W), .SIGNAL_W(SIGNAL_W),
        .SEL_W(SEL_W), .READ_LAT(READ_LAT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .samples_i(samples), .value_i(value), .index_o(index),
        .value_select_o(vsel), .busy_o(busy), .done_o(done), .stream(st.master)
    );

    always #5 clk = ~clk;

    // Sample buffer with one cycle of read latency.
    logic [DATA_W-1:0] mem [256][WORDS];
    always @(posedge clk) value <= mem[index][vsel];

    typedef struct {
        logic [DATA_W-1:0]   data;
        logic                last;
        logic [BUFFER_W-1:0] idx;
        logic [SEL_W-1:0]    sel;
    } word_t;

    typedef struct {
        int n;
        int stall;
        int abort_after;
        int exp_words;
        int exp_dones;
    } vec_t;

    word_t exp_q[$];
    int tests = 0, fails = 0, words_seen = 0, dones_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected stream: every word of every sample in order, last on the final one.
    task automatic prep(input int n);
        word_t w;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < WORDS; k++) begin
                mem[i][k] = $urandom;
                w.data = mem[i][k];
                w.last = (i == n - 1) && (k == WORDS - 1);
                w.idx  = BUFFER_W'(i);
                w.sel  = SEL_W'(k);
                exp_q.push_back(w);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done) dones_seen++;
            if (st.valid_o && st.ready_i && !abort) begin
                word_t w;
                words_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("data", st.data_o, w.data);
                    check("last", st.last_o, w.last);
                    check("index", index, w.idx);
                    check("value_select", vsel, w.sel);
                end
            end
        end
    end

    task automatic run_readout(input int n, input int stall, input int abort_after,
                               output int words, output int dones);
        int w0, d0;
        bit fin;
        w0 = words_seen;
        d0 = dones_seen;
        fin = 1'b0;
        prep(n);
        start = 1'b1;
        samples = BUFFER_W'(n);
        tick();
        start = 1'b0;
        samples = BUFFER_W'($urandom);
        for (int c = 0; c < 3000 && !fin; c++) begin
            abort = 1'b0;
            if (abort_after >= 0 && words_seen - w0 == abort_after && st.valid_o) begin
                abort = 1'b1;
                exp_q.delete();
            end
            st.ready_i = ($urandom_range(99) >= stall);
            tick();
            if (done) fin = 1'b1;
        end
        abort = 1'b0;
        st.ready_i = 1'b0;
        @(negedge clk);
        #1;
        if (!fin) check("readout_timeout", 0, 1);
        check("queue_drained", exp_q.size(), 0);
        check("idle_index", index, 0);
        check("idle_busy", busy, 0);
        words = words_seen - w0;
        dones = dones_seen - d0;
        tick();
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (st.valid_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("wait_valid_timeout", 0, 1);
    endtask

    vec_t vecs[7];
    int   words, dones;

    initial begin
        for (int i = 0; i < 256; i++)
            for (int k = 0; k < WORDS; k++) mem[i][k] = '0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; samples = '0; st.ready_i = 1'b0;
        repeat (3) tick();
        check("rst_index", index, 0);
        check("rst_sel", vsel, 0);
        check("rst_data", st.data_o, 0);
        check("rst_valid", st.valid_o, 0);
        check("rst_last", st.last_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // Table-driven readouts.
        vecs[0] = '{n: 3,   stall: 0,  abort_after: -1, exp_words: 6,   exp_dones: 1};
        vecs[1] = '{n: 2,   stall: 0,  abort_after: -1, exp_words: 4,   exp_dones: 1};
        vecs[2] = '{n: 1,   stall: 50, abort_after: -1, exp_words: 2,   exp_dones: 1};
        vecs[3] = '{n: 5,   stall: 0,  abort_after: 2,  exp_words: 2,   exp_dones: 1};
        vecs[4] = '{n: 5,   stall: 30, abort_after: 3,  exp_words: 3,   exp_dones: 1};
        vecs[5] = '{n: 0,   stall: 0,  abort_after: -1, exp_words: 0,   exp_dones: 1};
        vecs[6] = '{n: 255, stall: 0,  abort_after: -1, exp_words: 510, exp_dones: 1};
        foreach (vecs[i]) begin
            run_readout(vecs[i].n, vecs[i].stall, vecs[i].abort_after, words, dones);
            check($sformatf("vec%0d_words", i), words, vecs[i].exp_words);
            check($sformatf("vec%0d_dones", i), dones, vecs[i].exp_dones);
        end

        // Randomized readouts against the stream model.
        for (int r = 0; r < 20; r++) begin
            int n, stall;
            n = $urandom_range(0, 12);
            stall = $urandom_range(0, 60);
            run_readout(n, stall, -1, words, dones);
            check($sformatf("rand%0d_words", r), words, n * WORDS);
            check($sformatf("rand%0d_dones", r), dones, 1);
        end

        // Timing with ready held high: one word per READ_LAT+2 cycles.
        begin
            int vc[$];
            int donec;
            donec = -1;
            prep(2);
            st.ready_i = 1'b1;
            start = 1'b1; samples = 2;
            tick();
            start = 1'b0;
            check("busy_after_start", busy, 1);
            for (int c = 1; c <= 30; c++) begin
                tick();
                if (st.valid_o) vc.push_back(c);
                if (done && donec < 0) donec = c;
            end
            check("timing_word_count", vc.size(), 4);
            for (int k = 0; k < 4 && k < vc.size(); k++)
                check($sformatf("timing_word%0d_cycle", k), vc[k], 2 + 3 * k);
            check("timing_done_cycle", donec, 13);
            check("timing_drained", exp_q.size(), 0);
            st.ready_i = 1'b0;
        end

        // Zero samples: no words, done two cycles after start.
        begin
            bit any_valid;
            int donec, max_idx;
            any_valid = 1'b0; donec = -1; max_idx = 0;
            prep(0);
            st.ready_i = 1'b1;
            start = 1'b1; samples = 0;
            tick();
            start = 1'b0;
            for (int c = 1; c <= 5; c++) begin
                tick();
                if (st.valid_o) any_valid = 1'b1;
                if (done && donec < 0) donec = c;
                if (int'(index) > max_idx) max_idx = int'(index);
            end
            check("zero_no_valid", any_valid, 0);
            check("zero_done_cycle", donec, 1);
            check("zero_index", max_idx, 0);
            st.ready_i = 1'b0;
        end

        // Backpressure: word held stable for 5 stalled cycles.
        begin
            int w0;
            prep(2);
            w0 = words_seen;
            st.ready_i = 1'b0;
            start = 1'b1; samples = 2;
            tick();
            start = 1'b0;
            wait_valid();
            for (int c = 0; c < 5; c++) begin
                tick();
                check("stall_valid", st.valid_o, 1);
                check("stall_data", st.data_o, mem[0][0]);
                check("stall_last", st.last_o, 0);
                check("stall_index", index, 0);
            end
            st.ready_i = 1'b1;
            tick();
            check("stall_accepted_once", words_seen - w0, 1);
            check("stall_valid_drop", st.valid_o, 0);
            for (int c = 0; c < 40 && !done; c++) tick();
            check("stall_done", done, 1);
            check("stall_drained", exp_q.size(), 0);
            st.ready_i = 1'b0;
            tick();
        end

        // Abort after the 2nd of 5 samples' words, then a fresh readout from index 0.
        begin
            int w0;
            prep(5);
            w0 = words_seen;
            st.ready_i = 1'b1;
            start = 1'b1; samples = 5;
            tick();
            start = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (words_seen - w0 == 2 && st.valid_o) break;
                tick();
            end
            check("abort_reached", (words_seen - w0 == 2) && st.valid_o, 1);
            abort = 1'b1;
            exp_q.delete();
            tick();
            abort = 1'b0;
            check("abort_valid_drop", st.valid_o, 0);
            check("abort_busy_fin", busy, 1);
            tick();
            check("abort_done", done, 1);
            check("abort_idle", busy, 0);
            check("abort_words", words_seen - w0, 2);
            st.ready_i = 1'b0;
            tick();
            run_readout(3, 0, -1, words, dones);
            check("after_abort_words", words, 6);
        end

        // Reset in the middle of a readout while a word is valid.
        begin
            prep(4);
            st.ready_i = 1'b0;
            start = 1'b1; samples = 4;
            tick();
            start = 1'b0;
            wait_valid();
            rst = 1'b1;
            st.ready_i = 1'b1;
            tick();
            check("mid_rst_index", index, 0);
            check("mid_rst_sel", vsel, 0);
            check("mid_rst_data", st.data_o, 0);
            check("mid_rst_valid", st.valid_o, 0);
            check("mid_rst_last", st.last_o, 0);
            check("mid_rst_busy", busy, 0);
            check("mid_rst_done", done, 0);
            rst = 1'b0;
            st.ready_i = 1'b0;
            exp_q.delete();
            tick();
            run_readout(4, 20, -1, words, dones);
            check("after_rst_words", words, 8);
            check("after_rst_dones", dones, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
